dmem_lsu: RTL
=============

# dmem_lsu

Per-core load/store initiator for one data-memory port in the multicore MIPS. It takes load and store requests from the core's MEM stage and buffers stores in a small in-order store buffer. It drains that buffer into the dual-port data memory whenever the port is free and returns load data one cycle after acceptance. A fence handshake lets the core wait until all of its stores are globally visible before inter-core synchronisation.

## Interface
- DEPTH, 4, store-buffer entries; power of two, 2..8
- CLK  in  1  clock; all state updates on rising edge
- RSTB  in  1  reset, synchronous, active-low
- ReqValid  in  1  core presents a request
- ReqReady  out  1  request accepted this cycle when ReqValid && ReqReady
- ReqWrite  in  1  1 = store, 0 = load
- ReqAddr  in  32  byte address; bits [1:0] ignored (word access only)
- ReqWData  in  32  store data
- RespValid  out  1  one-cycle pulse; load data valid
- RespData  out  32  load result
- SyncReq  in  1  fence request (level)
- SyncDone  out  1  one-cycle pulse; buffer empty, fence complete
- BufCount  out  $clog2(DEPTH)+1  occupied entries
- MemAddr  out  32  to memory port address
- MemWE  out  1  to memory port write enable
- MemWData  out  32  to memory port write data
- MemRData  in  32  from memory port; combinational read of MemAddr

## Operation
- FSM states are IDLE and FENCE.
- ReqReady = (state==IDLE) && !SyncReq && (BufCount<DEPTH). The full-buffer condition also blocks loads.
- Accepted store: the entry {ReqAddr[31:2], ReqWData} is enqueued at the tail. No response is produced.
- Accepted load, same cycle:
  - MemAddr={ReqAddr[31:2],2'b00}, MemWE=0.
  - Next edge: RespData is taken from the youngest buffer entry whose word address matches, else from MemRData. RespValid=1 for one cycle.
- Drain: in every cycle with no accepted load and BufCount>0, the oldest entry is written.
  - MemWE=1, MemAddr={tag,2'b00}, MemWData=entry data.
  - The head pops at the edge.
- Store accept and drain in the same cycle leaves BufCount unchanged. The new entry goes behind the draining one.
- Idle port (no load, empty buffer): MemWE=0, MemAddr=0, MemWData=0.
- Fence:
  - IDLE with SyncReq=1 → FENCE at the next edge.
  - In FENCE, no requests are accepted and the buffer drains one entry per cycle.
  - When BufCount is 0, or is 1 and draining, the next edge moves to IDLE with SyncDone=1 for that cycle.
  - SyncReq must drop after SyncDone. If it is still high, a new fence starts; it completes immediately when the buffer is empty.
- Load priority means a stream of back-to-back loads can starve the drain. The core bounds this; the block does not.

## Timing
- Reset values: state IDLE, head/tail/BufCount 0, RespValid 0, RespData 0, SyncDone 0.
- MemWE is forced to 0 while RSTB=0.
- Reset mid-drain or mid-fence discards all buffered stores. No write is issued in the reset cycle.
- Load latency is 1 cycle, accept edge to RespValid. Loads can be accepted every cycle, giving full throughput.
- Store latency to memory is at least 1 cycle after accept, bounded by queue position and load traffic.
- Pointer wrap-around is modulo DEPTH. Full is BufCount==DEPTH and empty is BufCount==0, with no pointer-equality ambiguity.
- Fence latency from an empty buffer: SyncReq sampled → FENCE → SyncDone pulses 2 edges after SyncReq first seen.

## Configuration
- DMEM_FWD_EN defined: store-to-load forwarding as described; the youngest matching entry wins.
- DMEM_FWD_EN undefined:
  - ReqReady is additionally deasserted while ReqValid && !ReqWrite and any buffer entry matches ReqAddr[31:2].
  - The drain proceeds during the stall, and the load is accepted once no match remains.
  - RespData then always comes from MemRData.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE, FENCE);
  - the store entry struct {logic [29:0] tag; logic [31:0] data;};
  - the default DEPTH constant.
- Sub-module store_fifo is the circular buffer. It provides enqueue/dequeue, a count, a head-entry output, and a parallel address-match lookup returning a hit flag plus the youngest matching data.
- dmem_lsu holds the FSM, the port mux and the response register.

## Test plan
- Store 0x10←0xAAAA5555, then idle: MemWE=1, MemAddr=0x10, MemWData=0xAAAA5555 one cycle after accept; BufCount returns to 0.
- Stores 0x20←1 and 0x20←2, then load 0x23 next cycle:
  - With DMEM_FWD_EN: RespData=2 the following cycle.
  - Without DMEM_FWD_EN: ReqReady stays low until both entries drain, then RespData=2 from memory.
- DEPTH=4 stores with a continuous load stream to 0x100: BufCount reaches 4 and ReqReady drops. The fifth request is held, then accepted once loads stop and one drain completes.
- Three stores then SyncReq=1:
  - Three consecutive writes occur in order and SyncDone pulses exactly once.
  - ReqReady stays 0 from SyncReq until the cycle after SyncDone.
- RSTB=0 for one cycle with 3 buffered stores: no further MemWE; BufCount=0, RespValid=0, SyncDone=0 after the edge.
- Store and load (distinct addresses 0x40/0x44) on alternating cycles: every load returns memory data with 1-cycle latency, and all stores eventually drain in order.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory load/store initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state enum, store-buffer entry struct, default buffer depth.
package dmem_pkg;

  // Default store-buffer depth; must be a power of two in 2..8.
  localparam int DMEM_DEPTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FENCE = 1'b1
  } lsu_state_t;

  // One buffered store: word address (byte address bits [31:2]) and data.
  typedef struct packed {
    logic [29:0] tag;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_fifo.sv
// In-order circular store buffer with a parallel word-address lookup.
// Latency: push visible in count/head one edge later; lookup is combinational.
// Backpressure: none internally; the caller must not push when full or pop when empty.
// Ports:
//   CLK, RSTB         clock, synchronous active-low reset (clears pointers/count)
//   push, push_entry  enqueue at the tail
//   pop               dequeue the head
//   count             occupied entries (0..DEPTH)
//   head_entry        oldest entry
//   lookup_tag        word address to search for
//   hit, hit_data     any valid entry matches; data of the youngest match
module store_fifo
  import dmem_pkg::*;
#(
  parameter  int DEPTH = DMEM_DEPTH,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            push,
  input  sb_entry_t       push_entry,
  input  logic            pop,
  output logic [CW-1:0]   count,
  output sb_entry_t       head_entry,
  input  logic [29:0]     lookup_tag,
  output logic            hit,
  output logic [31:0]     hit_data
);

  sb_entry_t     mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] idx;

  // Pointers are exactly PW bits wide, so increments wrap modulo DEPTH.
  // Full/empty come from count, never from pointer equality.
  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_entry = mem[head];

  // Walk oldest to youngest so a later match overwrites an earlier one:
  // the surviving hit_data belongs to the youngest matching store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (mem[idx].tag == lookup_tag)) begin
        hit      = 1'b1;
        hit_data = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Per-core load/store initiator for one data-memory port, with store buffer and fence.
// Latency: load data 1 cycle after accept; stores reach memory >=1 cycle after accept.
// Backpressure: ReqReady low while fencing, SyncReq high, buffer full, or (no forwarding) a load hits the buffer.
// Build option: define DMEM_FWD_EN to forward buffered store data to loads instead of stalling them.
// Ports:
//   CLK, RSTB                    clock, synchronous active-low reset
//   ReqValid/ReqReady            request handshake; ReqWrite=1 store, 0 load
//   ReqAddr, ReqWData            byte address (word access), store data
//   RespValid, RespData          one-cycle load-data pulse and its data
//   SyncReq, SyncDone            fence request level, completion pulse
//   BufCount                     occupied store-buffer entries
//   MemAddr, MemWE, MemWData     memory port drive
//   MemRData                     combinational read data for MemAddr
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH
) (
  input  logic                     CLK,
  input  logic                     RSTB,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqWrite,
  input  logic [31:0]              ReqAddr,
  input  logic [31:0]              ReqWData,
  output logic                     RespValid,
  output logic [31:0]              RespData,
  input  logic                     SyncReq,
  output logic                     SyncDone,
  output logic [$clog2(DEPTH):0]   BufCount,
  output logic [31:0]              MemAddr,
  output logic                     MemWE,
  output logic [31:0]              MemWData,
  input  logic [31:0]              MemRData
);

  localparam int CW = $clog2(DEPTH) + 1;

  lsu_state_t    state;
  logic [CW-1:0] count;
  sb_entry_t     head_entry;
  sb_entry_t     new_entry;
  logic          hit;
  logic [31:0]   hit_data;
  logic          fwd_stall;
  logic          load_acc;
  logic          store_acc;
  logic          drain;
  logic          unused_bits;

`ifdef DMEM_FWD_EN
  assign fwd_stall   = 1'b0;
  assign unused_bits = ^ReqAddr[1:0];
`else
  // Without forwarding, a load to a buffered word waits for the drain.
  assign fwd_stall   = ReqValid && !ReqWrite && hit;
  assign unused_bits = ^{ReqAddr[1:0], hit_data};
`endif

  assign ReqReady  = (state == IDLE) && !SyncReq && (count < CW'(DEPTH)) && !fwd_stall;
  // Gating with RSTB keeps the reset cycle free of memory writes and buffer updates.
  assign load_acc  = RSTB && ReqValid && ReqReady && !ReqWrite;
  assign store_acc = RSTB && ReqValid && ReqReady && ReqWrite;
  // Loads own the port; the drain takes every other cycle with data waiting.
  assign drain     = RSTB && !load_acc && (count != '0);
  assign new_entry = {ReqAddr[31:2], ReqWData};
  assign BufCount  = count;

  store_fifo #(.DEPTH(DEPTH)) u_store_fifo (
    .CLK        (CLK),
    .RSTB       (RSTB),
    .push       (store_acc),
    .push_entry (new_entry),
    .pop        (drain),
    .count      (count),
    .head_entry (head_entry),
    .lookup_tag (ReqAddr[31:2]),
    .hit        (hit),
    .hit_data   (hit_data)
  );

  // Memory port mux: load read, else head drain, else parked at zero.
  always_comb begin
    MemAddr  = '0;
    MemWE    = 1'b0;
    MemWData = '0;
    if (load_acc) begin
      MemAddr = {ReqAddr[31:2], 2'b00};
    end else if (drain) begin
      MemWE    = 1'b1;
      MemAddr  = {head_entry.tag, 2'b00};
      MemWData = head_entry.data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTB) begin
      state     <= IDLE;
      RespValid <= 1'b0;
      RespData  <= '0;
      SyncDone  <= 1'b0;
    end else begin
      RespValid <= load_acc;
      if (load_acc) begin
`ifdef DMEM_FWD_EN
        RespData <= hit ? hit_data : MemRData;
`else
        RespData <= MemRData;
`endif
      end
      SyncDone <= 1'b0;
      case (state)
        IDLE: begin
          if (SyncReq) state <= FENCE;
        end
        FENCE: begin
          // Done once the last entry is gone or leaves at this edge.
          if ((count == '0) || ((count == CW'(1)) && drain)) begin
            state    <= IDLE;
            SyncDone <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
